reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_sync.sv | 26 ++
 rtl/reset_sequencer.sv | 101 ++++++++++
 tb/tb_reset_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer slice.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package reset_seq_pkg;

   // Sequencer phases: all selected stages held, staged release, normal operation.
   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   // Width of the hold/gap counter; HOLD_CYCLES and GAP_CYCLES must fit in it.
   localparam int CNT_W = 8;

   localparam int DEF_NUM_STAGES  = 4;
   localparam int DEF_HOLD_CYCLES = 8;
   localparam int DEF_GAP_CYCLES  = 4;

   // Counter value seen on the edge that ends an interval of 'cycles' edges.
   // The counter starts at 0 on the first edge of the interval.
   function automatic logic [CNT_W-1:0] cnt_last(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset bridge: asynchronous assert, two-flop synchronized deassert.
// Latency: output rises on the 2nd rising clk edge after async_rst_n rises; falls immediately.
// Backpressure: none.
module reset_sync (
   input  logic clk,
   input  logic async_rst_n,
   output logic rst_sync_n
);

   logic r_meta;
   logic r_sync;

   // Shift a constant 1 through two flops; asynchronous clear on reset assertion.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= 1'b1;
         r_sync <= r_meta;
      end
   end

   assign rst_sync_n = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds all selected stages, then releases them one by one in index order.
// Latency: stage k (k-th selected) drops HOLD_CYCLES + k*GAP_CYCLES edges after start; ack same edge as accept.
// Backpressure: software requests are only accepted in RUN; a held request waits until the sequence finishes.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
   input  logic                  clk,
   input  logic                  async_rst_n,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] sw_rst_mask,
   output logic                  sw_rst_ack,
   output logic                  rst_sync_n,
   output logic [NUM_STAGES-1:0] sync_rst,
   output logic                  busy,
   output logic                  done
);

   localparam logic [CNT_W-1:0] HOLD_LAST = cnt_last(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LAST  = cnt_last(GAP_CYCLES);

   logic                  w_rst_sync_n;
   logic [NUM_STAGES-1:0] w_pending;
   logic [NUM_STAGES-1:0] w_pending_next;
   logic [NUM_STAGES-1:0] w_req_mask;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [NUM_STAGES-1:0] r_mask;
   logic [NUM_STAGES-1:0] r_sync_rst;
   logic                  r_done;
   logic                  r_ack;

   reset_sync u_reset_sync (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .rst_sync_n  (w_rst_sync_n)
   );

   // Stages still waiting for release; the lowest set bit goes next, so
   // unselected stages are skipped without spending a gap interval.
   assign w_pending      = r_sync_rst & r_mask;
   assign w_pending_next = w_pending & (w_pending - NUM_STAGES'(1));

   // An empty mask would otherwise start a sequence with nothing to release.
   assign w_req_mask = (sw_rst_mask == '0) ? '1 : sw_rst_mask;

   // Sequencer FSM with counter and registered outputs.
   always_ff @(posedge clk or negedge w_rst_sync_n) begin
      if (!w_rst_sync_n) begin
         r_state    <= ST_HOLD;
         r_cnt      <= '0;
         r_mask     <= '1;
         r_sync_rst <= '1;
         r_done     <= 1'b0;
         r_ack      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_ack  <= 1'b0;
         case (r_state)
            ST_HOLD, ST_RELEASE: begin
               if (r_cnt == ((r_state == ST_HOLD) ? HOLD_LAST : GAP_LAST)) begin
                  r_sync_rst <= w_pending_next;
                  r_cnt      <= '0;
                  if (w_pending_next == '0) begin
                     r_state <= ST_RUN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RELEASE;
                  end
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (sw_rst_req) begin
                  r_ack      <= 1'b1;
                  r_mask     <= w_req_mask;
                  r_sync_rst <= w_req_mask;
                  r_cnt      <= '0;
                  r_state    <= ST_HOLD;
               end
            end
            default: begin
               r_state <= ST_HOLD;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign rst_sync_n = w_rst_sync_n;
   assign sync_rst   = r_sync_rst;
   assign busy       = (r_state != ST_RUN);
   assign done       = r_done;
   assign sw_rst_ack = r_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal 1-stage instance.
// Latency: checks sampled on the falling edge after each rising edge.
// Backpressure: exercises held software requests during an active sequence.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       req;
   logic [3:0] mask;
   logic       ack;
   logic       rsn;
   logic [3:0] srst;
   logic       busy;
   logic       done;

   logic       arst_n_min;
   logic       req_min;
   logic [0:0] mask_min;
   logic       ack_min;
   logic       rsn_min;
   logic [0:0] srst_min;
   logic       busy_min;
   logic       done_min;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reset_sequencer u_dut (
      .clk         (clk),
      .async_rst_n (arst_n),
      .sw_rst_req  (req),
      .sw_rst_mask (mask),
      .sw_rst_ack  (ack),
      .rst_sync_n  (rsn),
      .sync_rst    (srst),
      .busy        (busy),
      .done        (done)
   );

   reset_sequencer #(
      .NUM_STAGES  (1),
      .HOLD_CYCLES (1),
      .GAP_CYCLES  (1)
   ) u_min (
      .clk         (clk),
      .async_rst_n (arst_n_min),
      .sw_rst_req  (req_min),
      .sw_rst_mask (mask_min),
      .sw_rst_ack  (ack_min),
      .rst_sync_n  (rsn_min),
      .sync_rst    (srst_min),
      .busy        (busy_min),
      .done        (done_min)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Walk a full-select default sequence from cycle 'from_c' to 'to_c', where
   // cycle 0 is the edge at which the sequence started. Stage k drops at 8+4k,
   // done pulses at cycle 20 and busy is low from then on.
   task automatic run_seq(input int from_c, input int to_c, input string tag);
      logic [3:0] exp;
      for (int c = from_c; c <= to_c; c++) begin
         step(1);
         exp = 4'h0;
         for (int k = 0; k < 4; k++)
            if (c < 8 + 4 * k) exp[k] = 1'b1;
         check_val({tag, " sync_rst"}, 32'(srst), 32'(exp));
         check_val({tag, " done"},     32'(done), (c == 20) ? 1 : 0);
         check_val({tag, " busy"},     32'(busy), (c < 20) ? 1 : 0);
         check_val({tag, " ack"},      32'(ack),  0);
      end
   endtask

   // Release async reset at a falling edge and follow the power-on sequence.
   task automatic power_on(input string tag);
      arst_n = 1'b1;
      step(1);
      check_val({tag, " rsn after 1st edge"}, 32'(rsn), 0);
      step(1);
      check_val({tag, " rsn after 2nd edge"}, 32'(rsn), 1);
      check_val({tag, " sync_rst at rise"},   32'(srst), 'hF);
      check_val({tag, " busy at rise"},       32'(busy), 1);
      run_seq(1, 21, tag);
   endtask

   // Issue a software request for one edge and check the acceptance.
   task automatic sw_request(input logic [3:0] m, input logic [3:0] exp_rst, input string tag);
      req  = 1'b1;
      mask = m;
      step(1);
      check_val({tag, " ack"},      32'(ack),  1);
      check_val({tag, " sync_rst"}, 32'(srst), 32'(exp_rst));
      check_val({tag, " busy"},     32'(busy), 1);
      req  = 1'b0;
      mask = 4'h0;
   endtask

   initial begin
      arst_n     = 1'b0;
      req        = 1'b0;
      mask       = 4'h0;
      arst_n_min = 1'b0;
      req_min    = 1'b0;
      mask_min   = 1'b0;
      step(3);

      // Reset state.
      check_val("rst rsn",      32'(rsn),  0);
      check_val("rst sync_rst", 32'(srst), 'hF);
      check_val("rst busy",     32'(busy), 1);
      check_val("rst done",     32'(done), 0);
      check_val("rst ack",      32'(ack),  0);

      // Power-on with defaults.
      power_on("por");
      step(1);
      check_val("por done clears", 32'(done), 0);
      check_val("por run sync",    32'(srst), 0);

      // Partial mask 0101: bit0 at +8, bit2 at +12 with done, bits 1 and 3 stay low.
      sw_request(4'h5, 4'h5, "m5 accept");
      step(1);
      check_val("m5 ack one cycle", 32'(ack), 0);
      step(6);
      check_val("m5 +7 sync", 32'(srst), 'h5);
      step(1);
      check_val("m5 +8 sync", 32'(srst), 'h4);
      step(3);
      check_val("m5 +11 sync", 32'(srst), 'h4);
      check_val("m5 +11 done", 32'(done), 0);
      step(1);
      check_val("m5 +12 sync", 32'(srst), 'h0);
      check_val("m5 +12 done", 32'(done), 1);
      check_val("m5 +12 busy", 32'(busy), 0);
      step(1);
      check_val("m5 +13 done", 32'(done), 0);

      // All-zero mask behaves as all-ones, single ack.
      sw_request(4'h0, 4'hF, "m0 accept");
      run_seq(1, 21, "m0");

      // Request held from mid-release: no ack until the cycle after done.
      sw_request(4'hF, 4'hF, "held first");
      run_seq(1, 10, "held pre");
      req  = 1'b1;
      mask = 4'hF;
      run_seq(11, 20, "held wait");
      step(1);
      check_val("held ack after done", 32'(ack),  1);
      check_val("held second start",   32'(srst), 'hF);
      check_val("held busy",           32'(busy), 1);
      req  = 1'b0;
      mask = 4'h0;
      run_seq(1, 21, "held second");

      // Async reset mid-sequence aborts and restarts power-on.
      sw_request(4'h3, 4'h3, "abort start");
      step(10);
      check_val("abort +10 sync", 32'(srst), 'h2);
      #2 arst_n = 1'b0;
      #1;
      check_val("abort rsn",  32'(rsn),  0);
      check_val("abort sync", 32'(srst), 'hF);
      check_val("abort busy", 32'(busy), 1);
      check_val("abort done", 32'(done), 0);
      check_val("abort ack",  32'(ack),  0);
      req  = 1'b1;
      mask = 4'hF;
      step(3);
      check_val("abort held rsn", 32'(rsn), 0);
      check_val("abort held ack", 32'(ack), 0);
      req  = 1'b0;
      mask = 4'h0;
      power_on("repor");

      // Minimal instance: one stage, hold 1, gap 1.
      check_val("min rst sync", 32'(srst_min), 1);
      check_val("min rst busy", 32'(busy_min), 1);
      arst_n_min = 1'b1;
      step(2);
      check_val("min rsn rise",   32'(rsn_min),  1);
      check_val("min sync held",  32'(srst_min), 1);
      check_val("min done early", 32'(done_min), 0);
      step(1);
      check_val("min sync fall", 32'(srst_min), 0);
      check_val("min done",      32'(done_min), 1);
      check_val("min busy",      32'(busy_min), 0);
      step(1);
      check_val("min done clears", 32'(done_min), 0);
      req_min = 1'b1;
      step(1);
      check_val("min sw ack",  32'(ack_min),  1);
      check_val("min sw sync", 32'(srst_min), 1);
      req_min = 1'b0;
      step(1);
      check_val("min sw release", 32'(srst_min), 0);
      check_val("min sw done",    32'(done_min), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
